// File: rtl/adder_rr_scheduler_if.sv
// Bundle of the signals between the adder round-robin scheduler and its
// environment: the requester side, the shared pipelined adder and the
// response/status outputs.
//   master : the scheduler (drives grants, adder inputs, responses, status)
//   slave  : the environment (requesters plus the adder itself)
// Clock and reset are not part of the bundle; they stay plain ports.
interface adder_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int W    = 32
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [7:0]        add_tag;
    logic [W-1:0]      add_sum;
    logic [7:0]        add_tag_out;
    logic              rsp_valid;
    logic [2:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic [15:0]       issue_cnt;
    logic              tag_err;

    modport master (
        input  req_valid, req_a, req_b, add_sum, add_tag_out,
        output req_ready, add_a, add_b, add_tag,
        output rsp_valid, rsp_id, rsp_sum, issue_cnt, tag_err
    );

    modport slave (
        output req_valid, req_a, req_b, add_sum, add_tag_out,
        input  req_ready, add_a, add_b, add_tag,
        input  rsp_valid, rsp_id, rsp_sum, issue_cnt, tag_err
    );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Shares one fixed-latency pipelined adder among NREQ requesters.
// Round-robin grant, at most one issue per cycle, each requester limited to
// MAX_OUT operations in flight. A shadow shift register follows every issued
// op through the adder so the sum can be routed back to its owner; the
// adder's own tag is only cross-checked against it (tag_err).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active high
//   bus  : adder_rr_scheduler_if master modport
//          requester side  req_valid/req_a/req_b in, req_ready out (one-hot)
//          adder side      add_a/add_b/add_tag out, add_sum/add_tag_out in
//          response side   rsp_valid/rsp_id/rsp_sum, issue_cnt, tag_err out
module adder_rr_scheduler #(
    parameter int NREQ     = 4,
    parameter int W        = 32,
    parameter int PIPE_LAT = 4,
    parameter int MAX_OUT  = 2
) (
    input  logic clk,
    input  logic rst,
    adder_rr_scheduler_if.master bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int SD = PIPE_LAT + 1;

    logic [PW-1:0]   ptr;
    logic [CW-1:0]   out_cnt [NREQ];
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic            found;
    logic [2:0]      gid;
    logic [PW-1:0]   idx;
    int              s;
    logic            accept;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;

    logic [SD-1:0]   sr_vld;
    logic [2:0]      sr_id [SD];
    logic            tail_vld;
    logic [2:0]      tail_id;

    // Eligibility looks at the registered count only: a retire on the same
    // edge does not free a slot until the following cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++)
            eligible[i] = bus.req_valid[i] && (out_cnt[i] < CW'(MAX_OUT));
    end

    // First eligible requester at or after the pointer, wrapping.
    always_comb begin
        grant = '0;
        found = 1'b0;
        gid   = '0;
        idx   = '0;
        s     = 0;
        for (int off = 0; off < NREQ; off++) begin
            s = int'(ptr) + off;
            if (s >= NREQ) s = s - NREQ;
            idx = PW'(s);
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gid        = 3'(s);
            end
        end
    end

    assign bus.req_ready = grant & {NREQ{~rst}};
    assign accept        = found & ~rst;
    assign sel_a         = bus.req_a[int'(gid)*W +: W];
    assign sel_b         = bus.req_b[int'(gid)*W +: W];
    assign tail_vld      = sr_vld[SD-1];
    assign tail_id       = sr_id[SD-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.add_tag   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_sum   <= '0;
            bus.issue_cnt <= '0;
            bus.tag_err   <= 1'b0;
            sr_vld        <= '0;
            for (int i = 0; i < SD; i++) sr_id[i] <= '0;
            for (int i = 0; i < NREQ; i++) out_cnt[i] <= '0;
        end else begin
            if (accept) begin
                bus.add_a     <= sel_a;
                bus.add_b     <= sel_b;
                bus.add_tag   <= {1'b1, 4'b0000, gid};
                ptr           <= (int'(gid) == NREQ - 1) ? '0 : PW'(gid + 3'd1);
                bus.issue_cnt <= bus.issue_cnt + 16'd1;
            end else begin
                bus.add_tag   <= 8'h00;
            end

            sr_vld   <= {sr_vld[SD-2:0], accept};
            sr_id[0] <= gid;
            for (int i = 1; i < SD; i++) sr_id[i] <= sr_id[i-1];

            // Routing trusts the shadow register; the adder tag is only checked.
            bus.rsp_valid <= tail_vld;
            if (tail_vld) begin
                bus.rsp_id  <= tail_id;
                bus.rsp_sum <= bus.add_sum;
            end
            if ((tail_vld != bus.add_tag_out[7]) ||
                (tail_vld && (tail_id != bus.add_tag_out[2:0])))
                bus.tag_err <= 1'b1;

            for (int i = 0; i < NREQ; i++) begin
                if ((accept && gid == 3'(i)) && !(tail_vld && tail_id == 3'(i)))
                    out_cnt[i] <= out_cnt[i] + CW'(1);
                else if (!(accept && gid == 3'(i)) && (tail_vld && tail_id == 3'(i)))
                    out_cnt[i] <= out_cnt[i] - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler with a behavioural 4-stage adder
// that shares the scheduler's reset.
module tb_adder_rr_scheduler;
    localparam int NREQ     = 4;
    localparam int W        = 32;
    localparam int PIPE_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    adder_rr_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

    adder_rr_scheduler #(.NREQ(NREQ), .W(W), .PIPE_LAT(PIPE_LAT), .MAX_OUT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] sum_pipe [PIPE_LAT];
    logic [7:0]   tag_pipe [PIPE_LAT];
    wire  [7:0]   tag_out_m;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                sum_pipe[i] <= '0;
                tag_pipe[i] <= '0;
            end
        end else begin
            sum_pipe[0] <= bus.add_a + bus.add_b;
            tag_pipe[0] <= bus.add_tag;
            for (int i = 1; i < PIPE_LAT; i++) begin
                sum_pipe[i] <= sum_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out_m       = tag_pipe[PIPE_LAT-1];
    assign bus.add_tag_out = tag_out_m;
    assign bus.add_sum     = sum_pipe[PIPE_LAT-1];

    logic [34:0] rsp_q [$];
    always @(negedge clk) if (bus.rsp_valid) rsp_q.push_back({bus.rsp_id, bus.rsp_sum});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!bus.rsp_valid && n < 12) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_add_a"}, bus.add_a, 32'd0);
        chk({tag, "_add_b"}, bus.add_b, 32'd0);
        chk({tag, "_add_tag"}, 32'(bus.add_tag), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
        chk({tag, "_rsp_sum"}, bus.rsp_sum, 32'd0);
        chk({tag, "_issue_cnt"}, 32'(bus.issue_cnt), 32'd0);
        chk({tag, "_tag_err"}, 32'(bus.tag_err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] solo_exp;
        int          n_rsp;

        // reset, with requests pending: no grant while rst is high
        rst           = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        #1;
        chk("rst_ready_forced", 32'(bus.req_ready), 32'd0);
        tick();
        tick();
        chk_reset_vals("reset");
        rst           = 1'b0;
        bus.req_valid = 4'h0;

        // single op from requester 0, latency PIPE_LAT+1
        set_op(0, 32'd36865, 32'd33023);
        bus.req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'h0;
        chk("t1_add_tag", 32'(bus.add_tag), 32'h80);
        chk("t1_add_a", bus.add_a, 32'd36865);
        chk("t1_issue_cnt", 32'(bus.issue_cnt), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t1_rsp_early", 32'(bus.rsp_valid), 32'd0);
        end
        chk("t1_add_tag_idle", 32'(bus.add_tag), 32'h0);
        tick();
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t1_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("t1_rsp_sum", bus.rsp_sum, 32'd69888);
        tick();
        chk("t1_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
        chk("t1_rsp_hold", bus.rsp_sum, 32'd69888);

        // req1 then req2 back to back, responses on consecutive cycles
        set_op(1, 32'd9943121, -32'sd3302367);
        set_op(2, -32'sd3686, 32'd3023);
        bus.req_valid = 4'b0010;
        #1;
        chk("t2_ready1", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 4'b0100;
        #1;
        chk("t2_ready2", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 4'h0;
        wait_rsp("t2_rsp1_seen");
        chk("t2_rsp1_id", 32'(bus.rsp_id), 32'd1);
        chk("t2_rsp1_sum", bus.rsp_sum, 32'd6640754);
        tick();
        chk("t2_rsp2_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t2_rsp2_id", 32'(bus.rsp_id), 32'd2);
        chk("t2_rsp2_sum", bus.rsp_sum, -32'sd663);

        // req3 overflow wraps, no tag error
        set_op(3, 32'h7FFF_FFFF, 32'd1);
        bus.req_valid = 4'b1000;
        #1;
        chk("t3_ready", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = 4'h0;
        wait_rsp("t3_rsp_seen");
        chk("t3_rsp_id", 32'(bus.rsp_id), 32'd3);
        chk("t3_rsp_sum", bus.rsp_sum, 32'h8000_0000);
        chk("t3_tag_err", 32'(bus.tag_err), 32'd0);
        tick();

        // all four requesting, pointer at 0: strict rotation
        rsp_q.delete();
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'(100 * (i + 1)));
        bus.req_valid = 4'hF;
        #1;
        for (int c = 0; c < 12; c++) begin
            chk("t4_grant", 32'(bus.req_ready), 32'(1 << (c % 4)));
            tick();
        end
        bus.req_valid = 4'h0;
        repeat (8) tick();
        n_rsp = rsp_q.size();
        chk("t4_rsp_count", 32'(n_rsp), 32'd12);
        for (int j = 0; j < 12 && j < n_rsp; j++) begin
            chk("t4_rsp_id", 32'(rsp_q[j][34:32]), 32'(j % 4));
            chk("t4_rsp_sum", rsp_q[j][31:0], 32'(101 * (j % 4 + 1)));
        end
        chk("t4_issue_cnt", 32'(bus.issue_cnt), 32'd16);

        // req0 alone: credit limit of 2, retire frees a slot one cycle later
        solo_exp = 14'b11_0000_11_0000_11;
        set_op(0, 32'd1, 32'd1);
        bus.req_valid = 4'b0001;
        #1;
        for (int c = 0; c < 14; c++) begin
            chk("t5_throttle", 32'(bus.req_ready), 32'(solo_exp[13 - c]));
            tick();
        end
        bus.req_valid = 4'h0;
        chk("t5_issue_cnt", 32'(bus.issue_cnt), 32'd22);
        repeat (8) tick();

        // three ops in flight, reset two cycles after the last one
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = 4'h0;
        rsp_q.delete();
        tick();
        rst = 1'b1;
        tick();
        chk_reset_vals("t6_rst");
        rst = 1'b0;
        repeat (8) tick();
        chk("t6_no_rsp", 32'(rsp_q.size()), 32'd0);
        chk("t6_tag_err", 32'(bus.tag_err), 32'd0);

        // after reset the pointer restarts at 0; corrupt this op's returned tag
        set_op(0, 32'd5, 32'd7);
        bus.req_valid = 4'hF;
        #1;
        chk("t7_first_grant", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'h0;
        repeat (3) tick();
        chk("t7_tag_err_pre", 32'(bus.tag_err), 32'd0);
        tick();
        force tag_out_m = 8'h81;
        tick();
        release tag_out_m;
        chk("t7_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t7_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("t7_rsp_sum", bus.rsp_sum, 32'd12);
        chk("t7_tag_err", 32'(bus.tag_err), 32'd1);
        repeat (3) tick();
        chk("t7_tag_err_sticky", 32'(bus.tag_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_tag_err_clr", 32'(bus.tag_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
